// File: rtl/sum_display_pkg.sv
// Shared types and constants for the adder result display stage.
package sum_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DB_HIGH,
    HELD,
    DB_LOW
  } db_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/sum_display_hex_to_7seg.sv
// Hex nibble to active-low seven-segment pattern, bit order {g,f,e,d,c,b,a}.
module hex_to_7seg (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/sum_display.sv
// Captures the CLA adder operands/result on a debounced press and scans them
// onto the four-digit common-anode display.
module sum_display
  import sum_display_pkg::*;
#(
  parameter int REFRESH_DIV     = 100_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  logic [3:0] s,
  input  logic       cout,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       captured
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_DIV - 1);

  logic cap_meta, cap_s;
  db_state_t state, state_next;
  logic [DB_W-1:0]  db_cnt;
  logic             db_clear;
  logic [REF_W-1:0] ref_cnt;
  logic [1:0]       digit, digit_next;
  logic [3:0] a_q, b_q, s_q;
  logic       cin_q, cout_q, shown;
  logic [3:0] a_next, b_next, s_next, nibble;
  logic       cin_next, cout_next, shown_next;
  logic [6:0] hex_seg;

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_meta <= 1'b0;
      cap_s    <= 1'b0;
    end else begin
      cap_meta <= capture;
      cap_s    <= cap_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    db_clear   = 1'b0;
    case (state)
      IDLE: if (cap_s) begin
        state_next = DB_HIGH;
        db_clear   = 1'b1;
      end
      DB_HIGH: begin
        if (!cap_s)              state_next = IDLE;
        else if (db_cnt == DB_MAX) state_next = HELD;
      end
      HELD: if (!cap_s) begin
        state_next = DB_LOW;
        db_clear   = 1'b1;
      end
      default: begin
        if (cap_s)               state_next = HELD;
        else if (db_cnt == DB_MAX) state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    captured = (state == DB_HIGH) && cap_s && (db_cnt == DB_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      db_cnt <= '0;
    else if (db_clear)                            db_cnt <= '0;
    else if (state == DB_HIGH || state == DB_LOW) db_cnt <= db_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      digit   <= 2'd0;
    end else begin
      ref_cnt <= (ref_cnt == REF_MAX) ? '0 : ref_cnt + 1'b1;
      digit   <= digit_next;
    end
  end

  // The output register is fed from next-state values so the display reflects
  // a capture on the very next cycle and never shows a mixed digit.
  always_comb begin
    digit_next = (ref_cnt == REF_MAX) ? digit + 2'd1 : digit;
    a_next     = captured ? a    : a_q;
    b_next     = captured ? b    : b_q;
    s_next     = captured ? s    : s_q;
    cin_next   = captured ? cin  : cin_q;
    cout_next  = captured ? cout : cout_q;
    shown_next = captured | shown;
    case (digit_next)
      2'd0:    nibble = s_next;
      2'd1:    nibble = {3'b000, cout_next};
      2'd2:    nibble = b_next;
      default: nibble = a_next;
    endcase
  end

  hex_to_7seg u_hex (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= 4'h0;
      b_q    <= 4'h0;
      s_q    <= 4'h0;
      cin_q  <= 1'b0;
      cout_q <= 1'b0;
      shown  <= 1'b0;
      seg    <= SEG_BLANK;
      an     <= AN_OFF;
      dp     <= 1'b1;
    end else begin
      a_q    <= a_next;
      b_q    <= b_next;
      s_q    <= s_next;
      cin_q  <= cin_next;
      cout_q <= cout_next;
      shown  <= shown_next;
      seg    <= shown_next ? hex_seg : SEG_BLANK;
      an     <= shown_next ? ~(4'b0001 << digit_next) : AN_OFF;
      dp     <= ~(shown_next & (digit_next == 2'd0) & cin_next);
    end
  end

endmodule

// File: tb/tb_sum_display.sv
// Scoreboard bench for sum_display with a short refresh and debounce period.
module tb_sum_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       capture;
  logic [3:0] a, b, s;
  logic       cin, cout;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       captured;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pulses   = 0;

  typedef struct {
    logic [3:0] a, b, s;
    logic       cin, cout;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic shown_m = 1'b0;
  logic [3:0] prev_an = 4'hF;
  logic prev_lit = 1'b0;
  logic run_full = 1'b0;
  int   run_len  = 0;

  sum_display #(.REFRESH_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .s        (s),
    .cout     (cout),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .captured (captured)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] next_an(input logic [3:0] v);
    case (v)
      4'hE:    return 4'hD;
      4'hD:    return 4'hB;
      4'hB:    return 4'h7;
      default: return 4'hE;
    endcase
  endfunction

  // Monitor: display model check first, then pulse scoreboard, all on the falling edge.
  always @(negedge clk) begin
    if (rst || !shown_m) begin
      check("display_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      prev_an  = 4'hF;
      prev_lit = 1'b0;
      run_full = 1'b0;
    end else begin
      logic [6:0] exp_seg;
      logic       exp_dp;
      logic       valid;
      valid   = 1'b1;
      exp_dp  = 1'b1;
      exp_seg = 7'h7F;
      case (an)
        4'hE: begin exp_seg = hex7(cur.s); exp_dp = ~cur.cin; end
        4'hD: exp_seg = cur.cout ? 7'h79 : 7'h40;
        4'hB: exp_seg = hex7(cur.b);
        4'h7: exp_seg = hex7(cur.a);
        default: valid = 1'b0;
      endcase
      if (!valid) begin
        check("an_onehot", an, 4'hE);
      end else begin
        check("digit_content", {seg, dp}, {exp_seg, exp_dp});
        if (an != prev_an) begin
          if (prev_lit) check("scan_order", an, next_an(prev_an));
          if (run_full) check("scan_dwell", run_len, 4);
          run_full = prev_lit;
          prev_an  = an;
          run_len  = 1;
        end else begin
          run_len++;
        end
        prev_lit = 1'b1;
      end
    end

    if (rst) check("captured_in_reset", captured, 1'b0);
    if (captured) begin
      if (exp_q.size() == 0) begin
        check("pulse_unexpected", captured, 1'b0);
      end else begin
        cur = exp_q.pop_front();
        check("pulse_time", cyc, cur.due);
        shown_m = 1'b1;
        pulses++;
      end
    end else if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
      check("pulse_missing", captured, 1'b1);
      void'(exp_q.pop_front());
    end
    if (rst) shown_m = 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_inputs(input logic [3:0] va, vb, input logic vcin, input logic [3:0] vs, input logic vcout);
    a = va; b = vb; cin = vcin; s = vs; cout = vcout;
  endtask

  task automatic expect_pulse();
    exp_t e;
    e.a = a; e.b = b; e.s = s; e.cin = cin; e.cout = cout;
    e.due = cyc + 10;
    exp_q.push_back(e);
  endtask

  task automatic press(input int hold);
    capture = 1'b1;
    expect_pulse();
    tick(hold);
    capture = 1'b0;
    tick(12);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    capture = 1'b0;
    set_inputs(4'h0, 4'h0, 1'b0, 4'h0, 1'b0);
    tick(3);
    rst = 1'b0;
    tick(10);

    // Basic capture: 3 + 5 = 8.
    set_inputs(4'h3, 4'h5, 1'b0, 4'h8, 1'b0);
    press(20);
    tick(6);

    // Asynchronous reset mid-scan blanks the outputs within the same cycle.
    rst = 1'b1;
    #1;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_captured", captured, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(10);

    // Bounce rejection: four short pulses, then a real hold.
    set_inputs(4'h9, 4'h2, 1'b0, 4'hB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      capture = 1'b1;
      tick(3);
      capture = 1'b0;
      tick(3);
    end
    press(15);

    // Inputs change while held: no new pulse, display keeps the first values.
    set_inputs(4'h1, 4'h2, 1'b0, 4'h3, 1'b0);
    capture = 1'b1;
    expect_pulse();
    tick(14);
    set_inputs(4'hC, 4'hA, 1'b0, 4'h6, 1'b1);
    tick(6);
    capture = 1'b0;
    tick(12);
    press(15);
    tick(8);

    // Carry and decimal point: F + 1 + 1 = 0x11.
    set_inputs(4'hF, 4'h1, 1'b1, 4'h1, 1'b1);
    press(20);
    tick(8);

    // Reset during the high debounce discards the press.
    set_inputs(4'h7, 4'h7, 1'b0, 4'hE, 1'b0);
    capture = 1'b1;
    tick(4);
    rst = 1'b1;
    capture = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(25);

    check("queue_drained", exp_q.size(), 0);
    check("pulse_count", pulses, 5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
